// File: rtl/exp_table_reader_if.sv
// Bundle of table-fill, lookup request/response and status signals for exp_table_reader.
// Signal names are seen from the reader: i_* flow into it, o_* flow out of it.
interface exp_table_reader_if #(
    parameter int PATH_WIDTH = 10,
    parameter int DATA_WIDTH = 18
);
    logic [DATA_WIDTH-1:0] i_data;
    logic [PATH_WIDTH-1:0] i_addr;
    logic                  i_valid;
    logic                  i_done;
    logic                  i_flush;
    logic                  i_req_valid;
    logic [PATH_WIDTH-1:0] i_req_addr;
    logic                  o_req_ready;
    logic                  o_resp_valid;
    logic                  i_resp_ready;
    logic [DATA_WIDTH-1:0] o_resp_data;
    logic                  o_resp_err;
    logic                  o_table_ready;
    logic                  o_fill_err;
    logic [PATH_WIDTH-1:0] o_fill_count;

    modport slave (
        input  i_data, i_addr, i_valid, i_done, i_flush,
        input  i_req_valid, i_req_addr, i_resp_ready,
        output o_req_ready, o_resp_valid, o_resp_data, o_resp_err,
        output o_table_ready, o_fill_err, o_fill_count
    );

    modport master (
        output i_data, i_addr, i_valid, i_done, i_flush,
        output i_req_valid, i_req_addr, i_resp_ready,
        input  o_req_ready, o_resp_valid, o_resp_data, o_resp_err,
        input  o_table_ready, o_fill_err, o_fill_count
    );
endinterface

// File: rtl/exp_table_reader.sv
// Captures the exp(x*sigma) table stream into a RAM and serves 1-cycle-latency lookups.
// Optional macro EXP_TABLE_CLAMP_EN: clamp out-of-range lookups to the nearest table end.
//
// state     | meaning
// S_EMPTY   | no valid table; lookups stalled
// S_FILLING | generator streaming; counting writes, watching for bad addresses
// S_READY   | table complete; lookups accepted
module exp_table_reader #(
    parameter int X_MIN      = -307,
    parameter int X_MAX      = 280,
    parameter int PATH_WIDTH = 10,
    parameter int DATA_WIDTH = 18
) (
    input  logic                clk,
    input  logic                rst_n,
    exp_table_reader_if.slave   bus
);

    localparam int DEPTH = X_MAX - X_MIN + 1;
    localparam logic signed [PATH_WIDTH:0] XMIN_W   = (PATH_WIDTH+1)'(X_MIN);
    localparam logic signed [PATH_WIDTH:0] XMAX_W   = (PATH_WIDTH+1)'(X_MAX);
    localparam logic [PATH_WIDTH-1:0]      DEPTH_W  = PATH_WIDTH'(DEPTH);
    localparam logic [PATH_WIDTH-1:0]      LAST_IDX = PATH_WIDTH'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_EMPTY   = 2'd0,
        S_FILLING = 2'd1,
        S_READY   = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [PATH_WIDTH-1:0]   r_count;
    logic [PATH_WIDTH-1:0]   w_count_nxt;
    logic [PATH_WIDTH-1:0]   w_count_inc;
    logic                    r_bad;
    logic                    w_bad_nxt;
    logic                    r_fill_err;
    logic                    w_fill_err_nxt;
    logic                    r_table_ready;

    logic signed [PATH_WIDTH:0] w_wr_sx;
    logic                       w_wr_in;
    logic [PATH_WIDTH-1:0]      w_wr_idx;
    logic                       w_wr_en;

    logic signed [PATH_WIDTH:0] w_rd_sx;
    logic                       w_rd_lo;
    logic                       w_rd_hi;
    logic [PATH_WIDTH-1:0]      w_rd_idx;
    logic                       w_rd_miss;
    logic                       w_req_ready;
    logic                       w_accept;

    logic [DATA_WIDTH-1:0]   r_ram [0:DEPTH-1];
    logic [DATA_WIDTH-1:0]   r_ram_q;
    logic                    r_resp_valid;
    logic                    r_resp_err;
    logic                    r_data_zero;

    // Offsets are formed one bit wider so the signed subtract cannot wrap.
    assign w_wr_sx  = {bus.i_addr[PATH_WIDTH-1], bus.i_addr};
    assign w_wr_in  = (w_wr_sx >= XMIN_W) && (w_wr_sx <= XMAX_W);
    assign w_wr_idx = PATH_WIDTH'(w_wr_sx - XMIN_W);
    assign w_wr_en  = bus.i_valid && w_wr_in && !bus.i_flush;

    assign w_count_inc = (r_count == DEPTH_W) ? r_count : r_count + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_EMPTY;
            r_count       <= '0;
            r_bad         <= 1'b0;
            r_fill_err    <= 1'b0;
            r_table_ready <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_count       <= w_count_nxt;
            r_bad         <= w_bad_nxt;
            r_fill_err    <= w_fill_err_nxt;
            r_table_ready <= (w_state_nxt == S_READY);
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_count_nxt    = r_count;
        w_bad_nxt      = r_bad;
        w_fill_err_nxt = 1'b0;
        if (bus.i_flush) begin
            w_state_nxt = S_EMPTY;
            w_count_nxt = '0;
            w_bad_nxt   = 1'b0;
        end else begin
            case (r_state)
                S_EMPTY, S_READY: begin
                    if (bus.i_valid) begin
                        w_state_nxt = S_FILLING;
                        w_count_nxt = w_wr_in ? PATH_WIDTH'(1) : '0;
                        w_bad_nxt   = !w_wr_in;
                    end
                end
                S_FILLING: begin
                    if (bus.i_valid) begin
                        if (w_wr_in) w_count_nxt = w_count_inc;
                        else         w_bad_nxt   = 1'b1;
                    end
                    // Completion check sees a write landing in the same cycle as done.
                    if (bus.i_done) begin
                        if ((w_count_nxt == DEPTH_W) && !w_bad_nxt) begin
                            w_state_nxt = S_READY;
                        end else begin
                            w_state_nxt    = S_EMPTY;
                            w_fill_err_nxt = 1'b1;
                        end
                    end
                end
                default: w_state_nxt = S_EMPTY;
            endcase
        end
    end

    assign w_req_ready = (r_state == S_READY) && (!r_resp_valid || bus.i_resp_ready);
    assign w_accept    = bus.i_req_valid && w_req_ready;

    assign w_rd_sx = {bus.i_req_addr[PATH_WIDTH-1], bus.i_req_addr};
    assign w_rd_lo = (w_rd_sx < XMIN_W);
    assign w_rd_hi = (w_rd_sx > XMAX_W);

`ifdef EXP_TABLE_CLAMP_EN
    assign w_rd_idx  = w_rd_lo ? '0 : (w_rd_hi ? LAST_IDX : PATH_WIDTH'(w_rd_sx - XMIN_W));
    assign w_rd_miss = 1'b0;
`else
    assign w_rd_idx  = PATH_WIDTH'(w_rd_sx - XMIN_W);
    assign w_rd_miss = w_rd_lo || w_rd_hi;
`endif

    // Read port only fires on accept, so a stalled response keeps its word.
    always_ff @(posedge clk) begin
        if (w_wr_en) r_ram[w_wr_idx] <= bus.i_data;
        if (w_accept && !w_rd_miss) r_ram_q <= r_ram[w_rd_idx];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_data_zero  <= 1'b1;
        end else if (bus.i_flush) begin
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_data_zero  <= 1'b1;
        end else if (w_accept) begin
            r_resp_valid <= 1'b1;
            r_resp_err   <= w_rd_miss;
            r_data_zero  <= w_rd_miss;
        end else if (bus.i_resp_ready) begin
            r_resp_valid <= 1'b0;
        end
    end

    assign bus.o_req_ready   = w_req_ready;
    assign bus.o_resp_valid  = r_resp_valid;
    assign bus.o_resp_data   = r_data_zero ? '0 : r_ram_q;
    assign bus.o_resp_err    = r_resp_err;
    assign bus.o_table_ready = r_table_ready;
    assign bus.o_fill_err    = r_fill_err;
    assign bus.o_fill_count  = r_count;

endmodule

// File: tb/tb_exp_table_reader.sv
// Self-checking bench for exp_table_reader: fill/lookup vectors, stall, flush,
// fill-error and reset sequences, plus randomized lookups against a table model.
module tb_exp_table_reader;

    localparam int XL = -307;
    localparam int XH = 280;
    localparam int DEPTH = XH - XL + 1;
`ifdef EXP_TABLE_CLAMP_EN
    localparam bit CLAMP = 1'b1;
`else
    localparam bit CLAMP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    exp_table_reader_if #(.PATH_WIDTH(10), .DATA_WIDTH(18)) bus ();

    exp_table_reader #(.X_MIN(XL), .X_MAX(XH), .PATH_WIDTH(10), .DATA_WIDTH(18)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [17:0] mram [0:DEPTH-1];

    typedef struct {
        int          x;
        logic [17:0] d;
        logic        e;
    } vec_t;
    vec_t vecs [10];

    logic        pend_v;
    logic [17:0] pend_d;
    logic        pend_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_resp(input string tag, input logic v, input logic [17:0] d, input logic e);
        chk({tag, ".resp_valid"}, 32'(bus.o_resp_valid), 32'(v));
        if (v) begin
            chk({tag, ".resp_data"}, 32'(bus.o_resp_data), 32'(d));
            chk({tag, ".resp_err"}, 32'(bus.o_resp_err), 32'(e));
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".req_ready"},   32'(bus.o_req_ready), 0);
        chk({tag, ".resp_valid"},  32'(bus.o_resp_valid), 0);
        chk({tag, ".resp_data"},   32'(bus.o_resp_data), 0);
        chk({tag, ".resp_err"},    32'(bus.o_resp_err), 0);
        chk({tag, ".table_ready"}, 32'(bus.o_table_ready), 0);
        chk({tag, ".fill_err"},    32'(bus.o_fill_err), 0);
        chk({tag, ".fill_count"},  32'(bus.o_fill_count), 0);
    endtask

    function automatic void ref_lookup(input int x, output logic [17:0] d, output logic e);
        int k;
        k = x;
        e = 1'b0;
        if (x < XL || x > XH) begin
            if (!CLAMP) begin
                d = '0;
                e = 1'b1;
                return;
            end
            k = (x < XL) ? XL : XH;
        end
        d = mram[k - XL];
    endfunction

    task automatic drive_wr(input int x, input logic [17:0] d, input logic done);
        @(negedge clk);
        bus.i_valid = 1'b1;
        bus.i_addr  = 10'(x);
        bus.i_data  = d;
        bus.i_done  = done;
        if (x >= XL && x <= XH) mram[x - XL] = d;
    endtask

    task automatic idle_fill();
        @(negedge clk);
        bus.i_valid = 1'b0;
        bus.i_done  = 1'b0;
    endtask

    // Streams every x once; optionally shuffled with random data and done riding the last write.
    task automatic fill(input bit rnd, input string tag);
        int order [DEPTH];
        int j;
        int t;
        for (int i = 0; i < DEPTH; i++) order[i] = XL + i;
        if (rnd) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                j = $urandom_range(0, i);
                t = order[i]; order[i] = order[j]; order[j] = t;
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            drive_wr(order[i], rnd ? 18'($urandom) : 18'(order[i] - XL), rnd && (i == DEPTH - 1));
            if (i == 1) begin
                chk({tag, ".count_first"}, 32'(bus.o_fill_count), 1);
                chk({tag, ".ready_drop"}, 32'(bus.o_table_ready), 0);
            end
        end
        if (!rnd) begin
            @(negedge clk);
            bus.i_valid = 1'b0;
            bus.i_done  = 1'b1;
        end
        idle_fill();
        chk({tag, ".table_ready"}, 32'(bus.o_table_ready), 1);
        chk({tag, ".fill_count"}, 32'(bus.o_fill_count), DEPTH);
        chk({tag, ".fill_err"}, 32'(bus.o_fill_err), 0);
    endtask

    initial begin
        logic [17:0] ed;
        logic        ee;
        logic        exp_ready;
        int          x;
        int          raw;
        logic        rv;

        bus.i_data = '0; bus.i_addr = '0; bus.i_valid = 1'b0; bus.i_done = 1'b0;
        bus.i_flush = 1'b0; bus.i_req_valid = 1'b0; bus.i_req_addr = '0; bus.i_resp_ready = 1'b1;

        vecs[0] = '{-307, 18'd0,   1'b0};
        vecs[1] = '{0,    18'd307, 1'b0};
        vecs[2] = '{280,  18'd587, 1'b0};
        vecs[3] = '{-306, 18'd1,   1'b0};
        vecs[4] = '{279,  18'd586, 1'b0};
        vecs[5] = '{1,    18'd308, 1'b0};
        vecs[6] = '{300,  CLAMP ? 18'd587 : 18'd0, !CLAMP};
        vecs[7] = '{-308, 18'd0,   !CLAMP};
        vecs[8] = '{-512, 18'd0,   !CLAMP};
        vecs[9] = '{511,  CLAMP ? 18'd587 : 18'd0, !CLAMP};

        #12;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_all_zero("post_reset");

        // Sequential fill, then iDone
        fill(1'b0, "fill_seq");

        // Back-to-back lookups from the vector table, no gaps
        for (int i = 0; i <= 10; i++) begin
            @(negedge clk);
            if (i > 0) chk_resp($sformatf("vec%0d", i - 1), 1'b1, vecs[i-1].d, vecs[i-1].e);
            if (i < 10) begin
                bus.i_req_valid = 1'b1;
                bus.i_req_addr  = 10'(vecs[i].x);
                #1 chk($sformatf("vec%0d.req_ready", i), 32'(bus.o_req_ready), 1);
            end else begin
                bus.i_req_valid = 1'b0;
            end
        end
        @(negedge clk);
        chk("vec.drain_valid", 32'(bus.o_resp_valid), 0);

        // Response stall for three edges
        bus.i_req_valid = 1'b1; bus.i_req_addr = 10'(0); bus.i_resp_ready = 1'b1;
        @(negedge clk);
        chk_resp("stall.first", 1'b1, 18'd307, 1'b0);
        bus.i_resp_ready = 1'b0;
        bus.i_req_addr   = 10'(280);
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            chk_resp($sformatf("stall.hold%0d", k), 1'b1, 18'd307, 1'b0);
            chk($sformatf("stall.req_ready%0d", k), 32'(bus.o_req_ready), 0);
        end
        @(negedge clk);
        chk_resp("stall.held_last", 1'b1, 18'd307, 1'b0);
        bus.i_resp_ready = 1'b1;
        #1 chk("stall.resume_ready", 32'(bus.o_req_ready), 1);
        @(negedge clk);
        chk_resp("stall.next", 1'b1, 18'd587, 1'b0);
        bus.i_req_valid = 1'b0;
        @(negedge clk);
        chk("stall.drain_valid", 32'(bus.o_resp_valid), 0);

        // New generation straight from READY, shuffled random data, done with last write
        fill(1'b1, "fill_rnd");

        // Randomized lookups against the table model
        pend_v = 1'b0; pend_d = '0; pend_e = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            chk_resp("rnd", pend_v, pend_d, pend_e);
            if ($urandom_range(0, 7) == 0) begin
                raw = $urandom_range(0, 1023);
                x = (raw >= 512) ? raw - 1024 : raw;
            end else begin
                x = $urandom_range(0, DEPTH - 1) + XL;
            end
            rv = ($urandom_range(0, 3) != 0);
            bus.i_req_valid  = rv;
            bus.i_req_addr   = 10'(x);
            bus.i_resp_ready = ($urandom_range(0, 3) != 0);
            exp_ready = !pend_v || bus.i_resp_ready;
            #1 chk("rnd.req_ready", 32'(bus.o_req_ready), 32'(exp_ready));
            if (rv && exp_ready) begin
                ref_lookup(x, ed, ee);
                pend_v = 1'b1; pend_d = ed; pend_e = ee;
            end else if (bus.i_resp_ready) begin
                pend_v = 1'b0;
            end
        end
        @(negedge clk);
        bus.i_req_valid = 1'b0; bus.i_resp_ready = 1'b1;
        @(negedge clk);

        // Short fill: 100 writes then iDone -> one-cycle error pulse, back to EMPTY
        for (int i = 0; i < 100; i++) drive_wr(XL + i, 18'(i), 1'b0);
        @(negedge clk);
        chk("short.count", 32'(bus.o_fill_count), 100);
        bus.i_valid = 1'b0; bus.i_done = 1'b1;
        bus.i_req_valid = 1'b1; bus.i_req_addr = 10'(0);
        idle_fill();
        chk("short.fill_err", 32'(bus.o_fill_err), 1);
        chk("short.table_ready", 32'(bus.o_table_ready), 0);
        #1 chk("short.req_ready", 32'(bus.o_req_ready), 0);
        @(negedge clk);
        chk("short.fill_err_pulse", 32'(bus.o_fill_err), 0);
        chk("short.no_resp", 32'(bus.o_resp_valid), 0);
        bus.i_req_valid = 1'b0;

        // Complete count but one bad address seen -> fill error
        drive_wr(400, 18'h3ffff, 1'b0);
        for (int i = 0; i < DEPTH; i++) drive_wr(XL + i, 18'(i + 5), 1'b0);
        @(negedge clk);
        chk("bad.count", 32'(bus.o_fill_count), DEPTH);
        bus.i_valid = 1'b0; bus.i_done = 1'b1;
        idle_fill();
        chk("bad.fill_err", 32'(bus.o_fill_err), 1);
        chk("bad.table_ready", 32'(bus.o_table_ready), 0);

        // Flush in READY with a response pending
        fill(1'b0, "fill_again");
        bus.i_req_valid = 1'b1; bus.i_req_addr = 10'(400); bus.i_resp_ready = 1'b0;
        @(negedge clk);
        ref_lookup(400, ed, ee);
        chk_resp("flush.pending", 1'b1, ed, ee);
        bus.i_req_valid = 1'b0;
        bus.i_flush = 1'b1;
        @(negedge clk);
        bus.i_flush = 1'b0;
        #1 chk_all_zero("flush");
        bus.i_resp_ready = 1'b1;

        // Reset asserted mid-fill
        for (int i = 0; i < 50; i++) drive_wr(XL + i, 18'(i), 1'b0);
        @(negedge clk);
        chk("midfill.count", 32'(bus.o_fill_count), 50);
        #2 rst_n = 1'b0;
        bus.i_valid = 1'b0;
        #1 chk_all_zero("midfill.reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_all_zero("midfill.after");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
